// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 raster constants and lock-state type shared with the sync generator
package vga_pkg;
    localparam int COORD_W      = 10;
    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_TOTAL      = 525;
    localparam int LOCK_FRAMES  = 2;
    typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} lock_state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync line on the pixel strobe and flags its edges
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_in,
    output logic fall,
    output logic rise
);
    logic q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b1;
        else if (en) q <= sync_in;
    assign fall = q & ~sync_in;
    assign rise = ~q & sync_in;
endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: rebuilds pixel coordinates from hsync/vsync and tracks raster lock
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter int HA  = H_ACTIVE,
    parameter int HSS = H_SYNC_START,
    parameter int HSE = H_SYNC_END,
    parameter int HT  = H_TOTAL,
    parameter int VA  = V_ACTIVE,
    parameter int VSS = V_SYNC_START,
    parameter int VT  = V_TOTAL,
    parameter int LF  = LOCK_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    output logic                 valid,
    output logic                 newline,
    output logic                 newframe,
    output logic                 locked,
    output logic                 lost_lock,
    output logic [7:0]           err_count
);
    logic [COORD_W-1:0] px, py, nx, ny;
    logic hfall, hrise, vfall, vrise_unused, mm;
    lock_state_t state, nstate;
    logic [3:0] good, ngood;

    vga_sync_edge u_h (.clk(clk), .rst(rst), .en(pix_en), .sync_in(hsync_in), .fall(hfall), .rise(hrise));
    vga_sync_edge u_v (.clk(clk), .rst(rst), .en(pix_en), .sync_in(vsync_in), .fall(vfall), .rise(vrise_unused));

    // an edge and its predicted position must coincide, in both directions
    always_comb begin
        px = (x == COORD_W'(HT - 1)) ? '0 : x + 1'b1;
        py = (px != '0) ? y : (y == COORD_W'(VT - 1)) ? '0 : y + 1'b1;
        mm = (hfall != (px == COORD_W'(HSS))) |
             (hrise & (px != COORD_W'(HSE))) |
             (vfall != (px == '0 && py == COORD_W'(VSS)));
        nx = hfall ? COORD_W'(HSS) : px;
        ny = vfall ? COORD_W'(VSS) : py;
    end

    always_comb begin
        nstate = state;
        ngood  = good;
        if (state == ACQUIRE) begin
            if (vfall && !mm) begin
                nstate = TRACK;
                ngood  = '0;
            end
        end else if (mm) begin
            nstate = ACQUIRE;
        end else if (state == TRACK && vfall) begin
            ngood  = good + 1'b1;
            nstate = (ngood == 4'(LF)) ? LOCKED : TRACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            valid     <= 1'b0;
            newline   <= 1'b0;
            newframe  <= 1'b0;
            locked    <= 1'b0;
            lost_lock <= 1'b0;
            err_count <= '0;
            state     <= ACQUIRE;
            good      <= '0;
        end else begin
            newline   <= 1'b0;
            newframe  <= 1'b0;
            lost_lock <= 1'b0;
            if (pix_en) begin
                x        <= nx;
                y        <= ny;
                state    <= nstate;
                good     <= ngood;
                locked   <= nstate == LOCKED;
                valid    <= nstate == LOCKED && nx < COORD_W'(HA) && ny < COORD_W'(VA);
                newline  <= nx == '0;
                newframe <= nx == '0 && ny == '0;
                if (state == LOCKED && nstate == ACQUIRE) begin
                    lost_lock <= 1'b1;
                    if (err_count != 8'hff) err_count <= err_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives a scaled-down raster with faults and compares against a frame-level model
`timescale 1ns/1ps
module tb_vga_timing_rx;
    localparam int HA = 16, HSS = 18, HSE = 22, HT = 26;
    localparam int VA = 8, VSS = 10, VT = 13, LF = 2;

    logic clk = 0, rst = 1, pix_en = 0, hsync_in = 1, vsync_in = 1;
    logic [9:0] x, y;
    logic valid, newline, newframe, locked, lost_lock;
    logic [7:0] err_count;

    vga_timing_rx #(.HA(HA), .HSS(HSS), .HSE(HSE), .HT(HT), .VA(VA), .VSS(VSS), .VT(VT), .LF(LF)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .valid(valid), .newline(newline), .newframe(newframe),
        .locked(locked), .lost_lock(lost_lock), .err_count(err_count)
    );

    always #10 clk = ~clk;

    int checks = 0, failures = 0;
    int m_x, m_y, m_st, m_good, m_err;
    bit m_hs, m_vs, m_locked, m_valid, m_nl, m_nf, m_ll;
    int gx, gy, frame_no, cyc_n;
    int glitch_x = -1, glitch_y = -1, short_y = -1;
    bit vsupp = 0, first_mode = 0, seen_h, seen_v, prev_locked;
    int n_ll, n_nl, n_nf, n_val, last_nl = -1, last_nf = -1, nl_gap, nf_gap, lock_frame = -1;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_st = 0; m_good = 0; m_err = 0;
        m_hs = 1; m_vs = 1; m_locked = 0; m_valid = 0; m_nl = 0; m_nf = 0; m_ll = 0;
    endtask

    // st: 0 acquire, 1 tracking clean frames, 2 locked
    task automatic model_step(input bit en, input bit hs, input bit vs);
        int px, py, nx, ny;
        bit hf, hr, vf, mm;
        m_nl = 0; m_nf = 0; m_ll = 0;
        if (!en) return;
        px = (m_x + 1) % HT;
        py = (px == 0) ? (m_y + 1) % VT : m_y;
        hf = m_hs && !hs; hr = !m_hs && hs; vf = m_vs && !vs;
        m_hs = hs; m_vs = vs;
        mm = (hf != (px == HSS)) || (hr && px != HSE) || (vf != (px == 0 && py == VSS));
        nx = hf ? HSS : px;
        ny = vf ? VSS : py;
        if (m_st == 2 && mm) begin
            m_st = 0; m_ll = 1; m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (m_st == 1) begin
            if (mm) m_st = 0;
            else if (vf) begin m_good++; if (m_good == LF) m_st = 2; end
        end else if (m_st == 0 && vf && !mm) begin
            m_st = 1; m_good = 0;
        end
        m_x = nx; m_y = ny;
        m_locked = m_st == 2;
        m_valid = m_locked && nx < HA && ny < VA;
        m_nl = nx == 0;
        m_nf = nx == 0 && ny == 0;
    endtask

    task automatic compare_all(input bit en);
        chk("x", int'(x), m_x);
        chk("y", int'(y), m_y);
        chk("valid", int'(valid), int'(m_valid));
        chk("newline", int'(newline), int'(m_nl));
        chk("newframe", int'(newframe), int'(m_nf));
        chk("locked", int'(locked), int'(m_locked));
        chk("lost_lock", int'(lost_lock), int'(m_ll));
        chk("err_count", int'(err_count), m_err);
        if (lost_lock) n_ll++;
        if (newline) begin nl_gap = cyc_n - last_nl; last_nl = cyc_n; n_nl++; end
        if (newframe) begin nf_gap = cyc_n - last_nf; last_nf = cyc_n; n_nf++; end
        if (en && valid) n_val++;
        if (locked && !prev_locked && lock_frame < 0) lock_frame = frame_no;
        prev_locked = locked;
    endtask

    task automatic cyc(input bit en, input bit hs, input bit vs);
        pix_en = en; hsync_in = hs; vsync_in = vs;
        @(posedge clk);
        cyc_n++;
        if (rst) model_reset(); else model_step(en, hs, vs);
        #1 compare_all(en);
    endtask

    task automatic pixel(input int gap);
        bit hs, vs;
        hs = !(gx >= HSS && gx < HSE);
        if (gy == glitch_y && gx == glitch_x) hs = 0;
        if (gy == short_y && gx >= HSE - 2 && gx < HSE) hs = 1;
        vs = !(gy >= VSS && gy < VSS + 2) || vsupp;
        cyc(1, hs, vs);
        if (first_mode && !seen_h && gx == HSS) begin chk("first_hfall_x", int'(x), HSS); seen_h = 1; end
        if (first_mode && !seen_v && gx == 0 && gy == VSS) begin chk("first_vfall_y", int'(y), VSS); seen_v = 1; end
        repeat (gap) cyc(0, hs, vs);
        gx++;
        if (gx == HT) begin gx = 0; gy++; end
        if (gy == VT) begin gy = 0; frame_no++; end
    endtask

    task automatic run_frames(input int n, input bit rnd);
        int f;
        f = frame_no + n;
        while (frame_no < f) pixel(rnd ? $urandom_range(0, 2) : 1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_all(0);
        rst = 0;
        gx = 0; gy = 0; frame_no = 0;
        run_frames(4, 0);
        chk("lock_frame", lock_frame, 2);
        n_val = 0; n_nl = 0; n_nf = 0;
        run_frames(1, 0);
        chk("valid_per_frame", n_val, HA * VA);
        chk("newlines_per_frame", n_nl, VT);
        chk("newframes_per_frame", n_nf, 1);
        chk("newline_period", nl_gap, 2 * HT);
        chk("newframe_period", nf_gap, 2 * HT * VT);

        n_ll = 0; glitch_x = $urandom_range(2, HA - 1); glitch_y = $urandom_range(0, VA - 1);
        run_frames(1, 0);
        glitch_x = -1; glitch_y = -1;
        chk("glitch_lost_pulses", n_ll, 1);
        chk("glitch_err", int'(err_count), 1);
        run_frames(4, 1);
        chk("glitch_relock", int'(locked), 1);

        n_ll = 0; short_y = $urandom_range(0, VT - 1);
        run_frames(1, 1);
        short_y = -1;
        chk("width_lost_pulses", n_ll, 1);
        chk("width_err", int'(err_count), 2);
        run_frames(4, 1);
        chk("width_relock", int'(locked), 1);

        n_ll = 0; vsupp = 1;
        run_frames(1, 1);
        vsupp = 0;
        chk("vmiss_lost_pulses", n_ll, 1);
        chk("vmiss_err", int'(err_count), 3);
        run_frames(4, 1);
        chk("vmiss_relock", int'(locked), 1);

        @(negedge clk); #1 rst = 1;
        #1 model_reset(); compare_all(0);
        chk("async_rst_err", int'(err_count), 0);
        repeat (10) cyc(0, 1, 1);
        rst = 0;
        repeat (10) cyc(0, $urandom_range(0, 1), $urandom_range(0, 1));
        cyc(0, 1, 1);

        rst = 1; repeat (2) cyc(0, 1, 1); rst = 0;
        gx = 5; gy = 3; n_ll = 0; first_mode = 1; seen_h = 0; seen_v = 0;
        run_frames(4, 1);
        chk("mid_seen_hfall", int'(seen_h), 1);
        chk("mid_seen_vfall", int'(seen_v), 1);
        chk("mid_no_lost", n_ll, 0);
        chk("mid_locked", int'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receiver end of the 640x480@60 VGA timing interface.
- Consumes the active-low hsync/vsync pair plus the per-pixel strobe, and reconstructs the pixel coordinates.
- Outputs x/y, valid, newline and newframe.
- Checks sync timing against the nominal 800x525 raster, reports lock status and counts lock losses.
- Sits on the capture/loopback side: display-pipeline self-test, or a frame grabber fed by the sync generator.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC_START, 656, x of first hsync-low pixel
- H_SYNC_END, 752, x of first hsync-high pixel after the pulse
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines
- V_SYNC_START, 490, y of first vsync-low line
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  one-clk strobe per pixel; all sampling and counting occurs only when high
- hsync_in  in  1  horizontal sync, low during the pulse
- vsync_in  in  1  vertical sync, low during the pulse
- x  out  10  reconstructed column of the pixel sampled at the last pix_en
- y  out  10  reconstructed row
- valid  out  1  locked && x<H_ACTIVE && y<V_ACTIVE
- newline  out  1  one-clk pulse when x becomes 0
- newframe  out  1  one-clk pulse when x and y both become 0
- locked  out  1  high in LOCKED state
- lost_lock  out  1  one-clk pulse on LOCKED->ACQUIRE
- err_count  out  8  saturating count of lock losses

Behaviour:
- Reset (async, rst=1):
  - x=0, y=0, valid=0, newline=0, newframe=0.
  - locked=0, lost_lock=0, err_count=0.
  - hs_q=1, vs_q=1, state=ACQUIRE, good_frames=0.
  - Reset mid-frame discards all tracking.
- Strobe handling:
  - newline, newframe and lost_lock default to 0 every clk.
  - When pix_en=0, all other state holds.
- On pix_en=1, compute:
  - px = (x==H_TOTAL-1) ? 0 : x+1.
  - py = y; if px==0 then py = (y==V_TOTAL-1) ? 0 : y+1.
  - hfall = hs_q & ~hsync_in; hrise = ~hs_q & hsync_in; vfall = vs_q & ~vsync_in.
  - Then hs_q <= hsync_in and vs_q <= vsync_in.
- Mismatch is the OR of:
  - hfall && px!=H_SYNC_START
  - !hfall && px==H_SYNC_START
  - hrise && px!=H_SYNC_END
  - vfall && !(px==0 && py==V_SYNC_START)
  - !vfall && px==0 && py==V_SYNC_START
- Counter update:
  - x <= hfall ? H_SYNC_START : px.
  - y <= vfall ? V_SYNC_START : py.
  - This resyncs on every edge, in any state.
- newline/newframe: assert the same clk x/y are written, when the new x==0 (and the new y==0 for newframe).
- valid is registered, computed from the new x/y and the next-state locked.
- Lock FSM, evaluated on pix_en:
  - ACQUIRE: on vfall with no mismatch -> TRACK, good_frames=0.
  - TRACK:
    - Any mismatch -> ACQUIRE.
    - Otherwise, on vfall, good_frames++.
    - When good_frames reaches LOCK_FRAMES -> LOCKED, locked=1.
  - LOCKED: any mismatch -> ACQUIRE, locked=0, lost_lock=1, err_count++ (saturates at 255).
- Priority and simultaneous events:
  - rst over everything.
  - Within a pixel, mismatch beats vfall-count (mismatch on a vfall pixel -> ACQUIRE).
  - hfall and vfall on the same pixel both apply; this is expected at x=656 only if timing is corrupt, and is flagged.
- Latency: x/y/valid/newline/newframe update 1 clk after the pix_en sample; no further pipeline.
- Width: x,y are 10-bit unsigned. Wrap comparisons use parameters. No arithmetic exceeds 10 bits.

Decomposition:
- Shared package vga_pkg:
  - The eight timing constants above (the sync generator uses them too).
  - Lock-state enum {ACQUIRE, TRACK, LOCKED}.
  - Coordinate width (10).
- One sub-module, vga_sync_edge:
  - Registers a sync input on pix_en.
  - Outputs fall/rise pulses.
  - Instantiated twice (h, v).

Test Plan:
- Clean raster: 50 MHz clk, pix_en every 2nd clk, ideal syncs for 4 frames.
  - locked rises at the vfall of the 3rd frame.
  - Thereafter x/y match the generator's counters exactly.
  - newline every 1600 clks; newframe every 840000 clks; valid count per frame = 307200.
- Start mid-frame: release reset at generator x=100, y=200.
  - x=656 on the first hfall.
  - y=490 on the first vfall.
  - No lost_lock pulse.
- Glitch when locked: force hsync low for one pixel at x=300.
  - Mismatch detected; locked->0; lost_lock one pulse; err_count=1; valid=0.
  - Relock after 2 clean frames.
- Wrong pulse width: hsync high again at x=740 instead of 752 → mismatch, lock lost, err_count increments.
- Missing vsync: suppress one vsync pulse.
  - Mismatch at the predicted y=490,x=0 pixel.
  - Counters keep free-running (y wraps 524->0); lost_lock=1.
- Async reset while locked: assert rst between clk edges.
  - All outputs 0 immediately; err_count=0; state ACQUIRE.
  - pix_en held low afterwards: outputs stay constant.
